// File: rtl/kb_ascii_uart_tx_if.sv
// Scan-code FIFO read port: FWFT head data, empty flag and a one-cycle pop strobe.
interface kb_ascii_uart_tx_if;
    logic       kb_buf_empty;
    logic [7:0] key_code;
    logic       rd_key_code;

    // FIFO side
    modport master (
        output kb_buf_empty,
        output key_code,
        input  rd_key_code
    );

    // Consumer side
    modport slave (
        input  kb_buf_empty,
        input  key_code,
        output rd_key_code
    );
endinterface

// File: rtl/kb_ascii_uart_tx.sv
// Pops PS/2 set-2 make codes from the scan-code FIFO, maps them to ASCII and
// sends each as an 8N1 UART frame; the next pop waits until the stop bit ends.
module kb_ascii_uart_tx #(
    parameter int unsigned DVSR    = 163,
    parameter int unsigned SB_TICK = 16
) (
    input  logic                clk,
    input  logic                reset,
    kb_ascii_uart_tx_if.slave   kb,
    output logic                tx,
    output logic                tx_busy,
    output logic [7:0]          ascii
);

    localparam int unsigned BAUD_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned S_MAX  = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned S_W    = $clog2(S_MAX);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [2:0]         n_q, n_d;
    logic [7:0]         ascii_q, ascii_d;
    logic               tx_q, tx_d;
    logic               tx_busy_q, tx_busy_d;
    logic               rd_key_code_c;
    logic               tick;

    // Set-2 make code to ASCII; anything unrecognised becomes '*'.
    function automatic logic [7:0] lookup(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
            default: a = 8'h2A;
        endcase
        return a;
    endfunction

    assign tick = (baud_q == BAUD_W'(DVSR - 1));

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        s_d           = s_q;
        n_d           = n_q;
        ascii_d       = ascii_q;
        rd_key_code_c = 1'b0;

        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                // Pop is gated by reset so an aborted frame never steals the next key.
                if (!kb.kb_buf_empty && !reset) begin
                    rd_key_code_c = 1'b1;
                    ascii_d       = lookup(kb.key_code);
                    state_d       = START;
                    baud_d        = '0;
                    s_d           = '0;
                    n_d           = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d = '0;
                        if (n_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = ascii_d[n_d];
            default: tx_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            s_q       <= '0;
            n_q       <= '0;
            ascii_q   <= 8'h00;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            s_q       <= s_d;
            n_q       <= n_d;
            ascii_q   <= ascii_d;
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign kb.rd_key_code = rd_key_code_c;
    assign tx             = tx_q;
    assign tx_busy        = tx_busy_q;
    assign ascii          = ascii_q;

endmodule

// File: tb/tb_kb_ascii_uart_tx.sv
// Bench for kb_ascii_uart_tx: FIFO model feeds codes, a UART receiver decodes
// tx and compares each frame against a queue of expected ASCII bytes.
module tb_kb_ascii_uart_tx;

    localparam int unsigned DVSR    = 2;
    localparam int unsigned SB_TICK = 16;
    localparam int          BIT     = 16 * DVSR;
    localparam int          FRAME   = (16 * 9 + SB_TICK) * DVSR;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       tx_busy;
    logic [7:0] ascii;

    kb_ascii_uart_tx_if kb_if ();

    kb_ascii_uart_tx #(.DVSR(DVSR), .SB_TICK(SB_TICK)) dut (
        .clk     (clk),
        .reset   (rst),
        .kb      (kb_if.slave),
        .tx      (tx),
        .tx_busy (tx_busy),
        .ascii   (ascii)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];
    bit         pop_pend = 1'b0;
    int         pops = 0;
    int         frames = 0;
    int         cyc = 0;
    int         last_pop = 0;
    bit         last_pop_valid = 1'b0;
    logic       rd_prev = 1'b0;
    int         mstate = 0;
    int         mcnt = 0;
    logic [7:0] mbyte = 8'h00;
    vec_t       vecs[12];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic push(input vec_t v);
        fifo.push_back(v.code);
        exp_q.push_back(v.exp);
    endtask

    // FIFO model: head changes just after the edge that consumed the pop.
    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_pend = 1'b0;
        end
        kb_if.kb_buf_empty = (fifo.size() == 0);
        kb_if.key_code     = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Pop strobe rules: single cycle, only when idle, frames spaced by at least one idle clk.
    always @(negedge clk) begin
        cyc++;
        if (rst) last_pop_valid = 1'b0;
        if (kb_if.rd_key_code === 1'b1) begin
            chk("rd_single_cycle", 32'(rd_prev), 32'd0);
            chk("rd_only_idle", 32'(tx_busy), 32'd0);
            chk("rd_fifo_nonempty", 32'(kb_if.kb_buf_empty), 32'd0);
            if (last_pop_valid) chk("pop_spacing", 32'((cyc - last_pop) >= FRAME + 1), 32'd1);
            last_pop       = cyc;
            last_pop_valid = 1'b1;
            pops++;
            pop_pend = 1'b1;
        end
        rd_prev = kb_if.rd_key_code;
    end

    // UART receiver sampling each bit at its midpoint.
    always @(negedge clk) begin : rx_mon
        int k;
        if (rst) begin
            mstate = 0;
        end else begin
            case (mstate)
                0: if (tx === 1'b0) begin mstate = 1; mcnt = 1; end
                1: begin
                    mcnt++;
                    if (mcnt % BIT == BIT / 2) begin
                        k = mcnt / BIT;
                        if (k == 0)      chk("start_bit", 32'(tx), 32'd0);
                        else if (k <= 8) mbyte[k-1] = tx;
                        else             chk("stop_bit", 32'(tx), 32'd1);
                    end
                    if (mcnt == FRAME) begin
                        chk("stop_end_tx", 32'(tx), 32'd1);
                        chk("busy_in_frame", 32'(tx_busy), 32'd1);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", 32'(mbyte), 32'hFFFF_FFFF);
                        end else begin
                            logic [7:0] expb;
                            expb = exp_q.pop_front();
                            chk("frame_byte", 32'(mbyte), 32'(expb));
                            chk("ascii_hold", 32'(ascii), 32'(expb));
                        end
                        frames++;
                        mstate = 2;
                    end
                end
                2: begin
                    chk("gap_busy", 32'(tx_busy), 32'd0);
                    chk("gap_tx", 32'(tx), 32'd1);
                    mstate = 0;
                end
                default: mstate = 0;
            endcase
        end
    end

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (fifo.size() == 0 && exp_q.size() == 0 && mstate == 0 && !tx_busy && !pop_pend) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_rd(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (kb_if.rd_key_code === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rd_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        int p0;
        int f0;
        vecs[0]  = '{8'h1C, 8'h61};
        vecs[1]  = '{8'h16, 8'h31};
        vecs[2]  = '{8'h45, 8'h30};
        vecs[3]  = '{8'h5A, 8'h0D};
        vecs[4]  = '{8'h66, 8'h08};
        vecs[5]  = '{8'h77, 8'h2A};
        vecs[6]  = '{8'h1A, 8'h7A};
        vecs[7]  = '{8'h32, 8'h62};
        vecs[8]  = '{8'h29, 8'h20};
        vecs[9]  = '{8'hF0, 8'h2A};
        vecs[10] = '{8'h3D, 8'h37};
        vecs[11] = '{8'h46, 8'h39};

        // Reset with a key already waiting: nothing may be popped or driven.
        rst = 1'b1;
        @(posedge clk); #2;
        push(vecs[0]);
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(tx_busy), 32'd0);
            chk("rst_ascii", 32'(ascii), 32'd0);
            chk("rst_rd", 32'(kb_if.rd_key_code), 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;

        // Single frame 0x1C: exact busy length and first line level.
        wait_rd(100);
        @(negedge clk);
        chk("first_tx_low", 32'(tx), 32'd0);
        chk("first_ascii", 32'(ascii), 32'h61);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!tx_busy) break;
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(FRAME));
        wait_idle(100);

        // Back-to-back keys.
        @(posedge clk); #2;
        push(vecs[1]);
        push(vecs[2]);
        wait_idle(2 * FRAME + 100);

        // Table sweep, one key at a time.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            push(vecs[i]);
            wait_idle(FRAME + 100);
            chk("table_ascii", 32'(ascii), 32'(vecs[i].exp));
        end

        // Keys arriving while busy: exactly one pop per frame.
        p0 = pops;
        f0 = frames;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            push(vecs[i]);
            repeat ($urandom_range(0, 400)) @(posedge clk);
        end
        wait_idle(8 * (FRAME + 10) + 100);
        chk("pops_8", 32'(pops - p0), 32'd8);
        chk("frames_8", 32'(frames - f0), 32'd8);

        // Reset mid-DATA: frame aborts, queued key follows as a full frame.
        @(posedge clk); #2;
        push('{8'h24, 8'h65});
        push('{8'h2C, 8'h74});
        wait_rd(100);
        repeat (4 * BIT) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_rd", 32'(kb_if.rd_key_code), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        void'(exp_q.pop_front());
        wait_idle(FRAME + 100);
        chk("pending_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
